// File: rtl/wrp_din_pgen.sv
// Single-lane AXI4-Stream test-pattern source: ramp, constant, LFSR or impulse
// frames of packed cint16 pairs, with run control, frame and stall counters.
module wrp_din_pgen #(
    parameter int         FRAME_BEATS = 32768,
    parameter logic [3:0] LANE_ID     = 4'd0
) (
    input  logic        dat_clk,
    input  logic        dat_resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  cfg_mode,
    input  logic [15:0] cfg_nframes,
    input  logic [31:0] cfg_const,
    output logic        o_axi_tvld,
    input  logic        o_axi_trdy,
    output logic [63:0] o_axi_tdat,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [31:0] stall_cnt
);

    localparam int              BW   = (FRAME_BEATS > 2) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [BW-1:0]   LAST = BW'(FRAME_BEATS - 1);
    localparam logic [31:0]     SEED = 32'hACE1_0000 | {28'd0, LANE_ID};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e        state_q;
    logic          tvld_q;
    logic [63:0]   tdat_q;
    logic          busy_q;
    logic          fd_q;
    logic [15:0]   frame_cnt_q;
    logic [31:0]   stall_q;
    logic [BW-1:0] beat_q;
    logic [31:0]   lfsr_q;
    logic [1:0]    mode_q;
    logic [15:0]   nfr_q;
    logic [31:0]   const_q;

    logic          accept_d;
    logic          last_d;
    logic          end_run_d;
    logic [BW-1:0] beat_d;
    logic [31:0]   lfsr_d;
    logic [15:0]   frame_inc_d;

    // Fibonacci LFSR, taps 32,22,2,1, shifting left with feedback into bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [63:0] beat_data(input logic [1:0]    mode,
                                              input logic [BW-1:0] b,
                                              input logic [31:0]   l,
                                              input logic [31:0]   c);
        logic [14:0] b15;
        logic [63:0] d;
        b15 = 15'(b);
        d   = 64'd0;
        case (mode)
            2'd0:    d = {12'd0, LANE_ID, b15, 1'b1, 12'd0, LANE_ID, b15, 1'b0};
            2'd1:    d = {c, c};
            2'd2:    d = {l, ~l};
            default: d = (b == '0) ? 64'h0000_0000_0000_7FFF : 64'd0;
        endcase
        return d;
    endfunction

    always_comb begin
        accept_d    = tvld_q & o_axi_trdy;
        last_d      = (beat_q == LAST);
        beat_d      = last_d ? '0 : beat_q + BW'(1);
        lfsr_d      = lfsr_step(lfsr_q);
        frame_inc_d = frame_cnt_q + 16'd1;
        // A stop arriving on the last beat's acceptance edge closes the run there.
        end_run_d   = (state_q == DRAIN) || stop ||
                      ((nfr_q != 16'd0) && (frame_inc_d == nfr_q));
    end

    always_ff @(posedge dat_clk or negedge dat_resetn) begin
        if (!dat_resetn) begin
            state_q     <= IDLE;
            tvld_q      <= 1'b0;
            tdat_q      <= 64'd0;
            busy_q      <= 1'b0;
            fd_q        <= 1'b0;
            frame_cnt_q <= 16'd0;
            stall_q     <= 32'd0;
            beat_q      <= '0;
            lfsr_q      <= 32'd0;
            mode_q      <= 2'd0;
            nfr_q       <= 16'd0;
            const_q     <= 32'd0;
        end else begin
            fd_q <= 1'b0;
            if (tvld_q && !o_axi_trdy && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;

            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        mode_q      <= cfg_mode;
                        nfr_q       <= cfg_nframes;
                        const_q     <= cfg_const;
                        beat_q      <= '0;
                        frame_cnt_q <= 16'd0;
                        stall_q     <= 32'd0;
                        lfsr_q      <= SEED;
                        tdat_q      <= beat_data(cfg_mode, '0, SEED, cfg_const);
                        tvld_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                default: begin
                    if (accept_d) begin
                        beat_q <= beat_d;
                        lfsr_q <= lfsr_d;
                        tdat_q <= beat_data(mode_q, beat_d, lfsr_d, const_q);
                        if (last_d) begin
                            frame_cnt_q <= frame_inc_d;
                            fd_q        <= 1'b1;
                        end
                    end
                    if (accept_d && last_d && end_run_d) begin
                        tvld_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (state_q == RUN && stop) begin
                        state_q <= DRAIN;
                    end
                end
            endcase
        end
    end

    assign o_axi_tvld = tvld_q;
    assign o_axi_tdat = tdat_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign frame_cnt  = frame_cnt_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_wrp_din_pgen.sv
// Directed bench for wrp_din_pgen: 8-beat frames, lane 3, hand-computed beats.
module tb_wrp_din_pgen;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] nframes = 16'd0;
    logic [31:0] cconst = 32'd0;
    logic        tvld;
    logic        trdy = 1'b1;
    logic [63:0] tdat;
    logic        busy;
    logic        fdone;
    logic [15:0] fcnt;
    logic [31:0] scnt;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] beats[$];
    int          vld_cycles = 0;
    int          stall_seen = 0;
    int          fd_cnt = 0;
    logic        fd_busy = 1'b1;
    logic        fd_vld = 1'b1;
    logic        prev_stall = 1'b0;
    logic [63:0] held = 64'd0;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    wrp_din_pgen #(.FRAME_BEATS(8), .LANE_ID(4'd3)) dut (
        .dat_clk(clk), .dat_resetn(resetn), .start(start), .stop(stop),
        .cfg_mode(mode), .cfg_nframes(nframes), .cfg_const(cconst),
        .o_axi_tvld(tvld), .o_axi_trdy(trdy), .o_axi_tdat(tdat),
        .busy(busy), .frame_done(fdone), .frame_cnt(fcnt), .stall_cnt(scnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ramp(input int b);
        return {16'h0003, 16'(2 * b + 1), 16'h0003, 16'(2 * b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        vld_cycles = 0;
        stall_seen = 0;
        fd_cnt     = 0;
        fd_busy    = 1'b1;
        fd_vld     = 1'b1;
    endtask

    task automatic run_start(input logic [1:0] m, input logic [15:0] nf);
        clear_mon();
        mode    = m;
        nframes = nf;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            trdy = toggle ? pat[i % 4] : 1'b1;
            tick();
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 64'(busy), 64'd0);
        trdy = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Beats are logged on the negedge before the edge that accepts them.
    always @(negedge clk) begin
        if (tvld) begin
            vld_cycles++;
            if (prev_stall) check("tdat_hold", tdat, held);
            if (trdy) beats.push_back(tdat);
            else stall_seen++;
        end
        if (fdone) begin
            fd_cnt++;
            fd_busy = busy;
            fd_vld  = tvld;
        end
        prev_stall = tvld && !trdy;
        held       = tdat;
    end

    initial begin
        tick();
        tick();
        check("rst_tvld", 64'(tvld), 64'd0);
        check("rst_tdat", tdat, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fdone", 64'(fdone), 64'd0);
        check("rst_fcnt", 64'(fcnt), 64'd0);
        check("rst_scnt", 64'(scnt), 64'd0);
        resetn = 1'b1;
        tick();

        // Ramp, two frames, ready always high.
        run_start(2'd0, 16'd2);
        check("t1_busy0", 64'(busy), 64'd1);
        check("t1_vld0", 64'(tvld), 64'd1);
        check("t1_beat0", tdat, ramp(0));
        wait_idle(100, 1'b0);
        check("t1_nbeats", 64'(beats.size()), 64'd16);
        check("t1_vldcyc", 64'(vld_cycles), 64'd16);
        if (beats.size() == 16) begin
            check("t1_beat5", beats[5], 64'h0003_000B_0003_000A);
            for (int i = 0; i < 16; i++) check("t1_seq", beats[i], ramp(i % 8));
        end
        check("t1_fdcnt", 64'(fd_cnt), 64'd2);
        check("t1_fdbusy", 64'(fd_busy), 64'd0);
        check("t1_fdvld", 64'(fd_vld), 64'd0);
        check("t1_fcnt", 64'(fcnt), 64'd2);
        check("t1_scnt", 64'(scnt), 64'd0);

        // Same run with ready toggling 1,0,0,1.
        run_start(2'd0, 16'd2);
        wait_idle(200, 1'b1);
        check("t2_nbeats", 64'(beats.size()), 64'd16);
        if (beats.size() == 16)
            for (int i = 0; i < 16; i++) check("t2_seq", beats[i], ramp(i % 8));
        check("t2_stalls_seen", 64'(stall_seen > 0), 64'd1);
        check("t2_scnt", 64'(scnt), 64'(stall_seen));
        check("t2_fcnt", 64'(fcnt), 64'd2);

        // Continuous run, stop (with a coincident start) at frame 1 beat 3.
        run_start(2'd0, 16'd0);
        repeat (11) tick();
        check("t3_at_stop", tdat, ramp(3));
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        wait_idle(100, 1'b0);
        check("t3_nbeats", 64'(beats.size()), 64'd16);
        if (beats.size() == 16) check("t3_lastbeat", beats[15], ramp(7));
        check("t3_fcnt", 64'(fcnt), 64'd2);
        check("t3_fdcnt", 64'(fd_cnt), 64'd2);
        check("t3_vld_end", 64'(tvld), 64'd0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t3_ss_busy", 64'(busy), 64'd0);
        check("t3_ss_vld", 64'(tvld), 64'd0);
        check("t3_ss_fcnt", 64'(fcnt), 64'd2);

        // LFSR, one frame, seed ACE1_0003 for lane 3; rerun must repeat.
        for (int r = 0; r < 2; r++) begin
            run_start(2'd2, 16'd1);
            wait_idle(100, 1'b0);
            check("t4_nbeats", 64'(beats.size()), 64'd8);
            if (beats.size() == 8) begin
                check("t4_b0", beats[0], 64'hACE1_0003_531E_FFFC);
                check("t4_b1", beats[1], 64'h59C2_0006_A63D_FFF9);
                check("t4_b2", beats[2], 64'hB384_000D_4C7B_FFF2);
            end
            check("t4_fcnt", 64'(fcnt), 64'd1);
        end

        // Constant, with cfg_const changed mid-run.
        cconst = 32'h1234_ABCD;
        run_start(2'd1, 16'd1);
        cconst = 32'hDEAD_BEEF;
        wait_idle(100, 1'b0);
        check("t5_nbeats", 64'(beats.size()), 64'd8);
        if (beats.size() == 8) check("t5_b7", beats[7], 64'h1234_ABCD_1234_ABCD);

        // Impulse, three frames.
        run_start(2'd3, 16'd3);
        wait_idle(100, 1'b0);
        check("t6_nbeats", 64'(beats.size()), 64'd24);
        if (beats.size() == 24)
            for (int i = 0; i < 24; i++)
                check("t6_seq", beats[i], (i % 8 == 0) ? 64'h0000_0000_0000_7FFF : 64'd0);
        check("t6_fcnt", 64'(fcnt), 64'd3);

        // Asynchronous reset mid-frame during a stall.
        run_start(2'd0, 16'd0);
        repeat (3) tick();
        trdy = 1'b0;
        repeat (2) tick();
        check("t7_stall_scnt", 64'(scnt), 64'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("t7_rst_vld", 64'(tvld), 64'd0);
        check("t7_rst_tdat", tdat, 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_fcnt", 64'(fcnt), 64'd0);
        check("t7_rst_scnt", 64'(scnt), 64'd0);
        check("t7_rst_fdone", 64'(fdone), 64'd0);
        tick();
        resetn = 1'b1;
        trdy   = 1'b1;
        tick();
        run_start(2'd0, 16'd0);
        check("t7_re_beat0", tdat, ramp(0));
        check("t7_re_fcnt", 64'(fcnt), 64'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(100, 1'b0);
        check("t7_re_nbeats", 64'(beats.size()), 64'd8);
        check("t7_re_fcnt_end", 64'(fcnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wrp_din_pgen.md
# wrp_din_pgen

Single-lane AXI4-Stream test-pattern source that sits directly upstream of the data-input wrapper. It drives one customer-logic input lane (`iNa`/`iNb`) with frames of packed cint16 samples, two per 64-bit beat. Sixteen instances, one per lane, feed the 1M-point FFT with known stimulus for bring-up and throughput measurement.

## Interface
Parameters:
- `FRAME_BEATS`, 32768: beats per frame (1M points / 16 lanes / 2 samples per beat); must be ≥2.
- `LANE_ID`, 0: 4-bit lane index used in ramp and LFSR seed.

Ports:
- `dat_clk`  in  1: data-plane clock, 300 MHz.
- `dat_resetn`  in  1: reset; one clock; reset is asynchronous and active-low.
- `start`  in  1: one-cycle pulse, begin a run.
- `stop`  in  1: one-cycle pulse, end the run at the next frame boundary.
- `cfg_mode`  in  2: 0 ramp, 1 constant, 2 LFSR, 3 impulse.
- `cfg_nframes`  in  16: frames per run; 0 = continuous.
- `cfg_const`  in  32: constant sample {im[15:0], re[15:0]} for mode 1.
- `o_axi_tvld`  out  1: stream valid.
- `o_axi_trdy`  in  1: stream ready, from the wrapper lane.
- `o_axi_tdat`  out  64: {im1, re1, im0, re0}, 16 bits each.
- `busy`  out  1: run in progress.
- `frame_done`  out  1: one-cycle pulse per completed frame.
- `frame_cnt`  out  16: frames completed in the current or last run.
- `stall_cnt`  out  32: cycles with tvld=1 and trdy=0, saturating.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- IDLE → RUN on `start` when `stop`=0. On that edge:
  - `cfg_*` are latched, so changes during a run have no effect.
  - `beat_cnt`, `frame_cnt` and `stall_cnt` are cleared.
  - The LFSR is seeded to 32'hACE1_0000 | LANE_ID.
- RUN → DRAIN on `stop`. DRAIN keeps streaming until the last beat of the current frame is accepted, then goes to IDLE.
- RUN → IDLE when the last beat of frame number `cfg_nframes` is accepted (nframes≠0).
- `start` outside IDLE is ignored. `stop` in IDLE is ignored. If `start` and `stop` arrive in the same IDLE cycle, `stop` wins and the block stays IDLE.
- A beat is accepted when tvld & trdy. Only acceptance advances `beat_cnt` and the LFSR.
- `beat_cnt` counts 0..FRAME_BEATS-1 and wraps to 0. At the wrap, `frame_cnt` increments, wrapping at 16 bits.
- Beat data for `beat_cnt` = b:
  - Ramp: re0 = {b[14:0],0}, re1 = {b[14:0],1}, im0 = im1 = {12'd0, LANE_ID}.
  - Constant: both samples = `cfg_const`.
  - LFSR: tdat = {L, ~L}, where L is the current 32-bit Fibonacci LFSR with taps 32,22,2,1, shifting left with feedback into bit 0.
  - Impulse: b = 0 gives re0 = 16'h7FFF and all other fields 0; b ≠ 0 gives all fields 0.
- `stall_cnt` increments on each cycle with tvld & ~trdy and saturates at 32'hFFFF_FFFF.
- `busy` = (state ≠ IDLE).

## Timing
- On reset, asynchronously: tvld=0, tdat=0, busy=0, frame_done=0, frame_cnt=0, stall_cnt=0, state=IDLE. An assertion mid-run aborts immediately, with no frame completion.
- `o_axi_tdat`, `o_axi_tvld` and `busy` are registered outputs.
- Latency: `start` sampled at edge k gives busy=1 and tvld=1 with beat 0 after edge k.
- AXIS rules:
  - While tvld=1 and trdy=0, tdat holds stable.
  - tvld never drops without a handshake.
  - tvld does not depend combinationally on trdy.
- With trdy held at 1 the block sustains one beat per cycle, with no bubble across frame boundaries.
- `frame_done` is high for exactly the one cycle after the edge at which the last beat of a frame is accepted.
- On the final beat's acceptance edge, tvld and busy go to 0 on the next cycle, coincident with `frame_done`.
- A `stop` pulse arriving on the same edge that accepts a frame's last beat ends the run at that boundary: no further frame is sent.

## Test plan
- FRAME_BEATS=8, LANE_ID=3, ramp, nframes=2, trdy=1:
  - Exactly 16 beats in 16 consecutive cycles; beat 5 tdat = 64'h0003_000B_0003_000A.
  - frame_done pulses twice; frame_cnt=2; busy falls with the 2nd pulse; stall_cnt=0.
- Same setup, trdy toggling 1,0,0,1,…:
  - tdat stable during every stall; the beat sequence is identical to the previous test.
  - stall_cnt equals the number of cycles with tvld=1 and trdy=0.
- Continuous run (nframes=0), `stop` pulsed at beat 3 of frame 1:
  - Beats 4..7 of frame 1 are still sent, then tvld=0.
  - frame_cnt=2; `start` pulses in the same cycle as `stop` are ignored.
- LFSR mode, LANE_ID=0, nframes=1: beat 0 = {32'hACE1_0000, 32'h531E_FFFF}; beat 1 is one LFSR step later. A new run reseeds and repeats the sequence.
- Impulse mode, FRAME_BEATS=8, nframes=3: beats 0, 8 and 16 equal 64'h0000_0000_0000_7FFF; every other beat is 0.
- Reset asserted mid-frame during a stall: all outputs return to their reset values asynchronously. After release, `start` restarts from beat 0 with frame_cnt=0.
